// File: rtl/waves_nios_led_pkg.sv
// Shared register map and field positions for the Nios LED controller.
package waves_nios_led_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_MODE   = 3'd1;
  localparam logic [2:0] ADDR_DUTY   = 3'd2;
  localparam logic [2:0] ADDR_PRESC  = 3'd3;
  localparam logic [2:0] ADDR_SET    = 3'd4;
  localparam logic [2:0] ADDR_CLEAR  = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  localparam logic MODE_STATIC = 1'b0;
  localparam logic MODE_PWM    = 1'b1;

  localparam int unsigned STATUS_PENDING_BIT = 0;
  localparam int unsigned STATUS_DUTY_LSB    = 16;

endpackage

// File: rtl/waves_nios_led_pwm_timer.sv
// Prescaler plus free-running PWM counter; flags the last tick of each PWM period.
module waves_nios_led_pwm_timer #(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned PRESC_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PRESC_BITS-1:0] presc,
  input  logic                  presc_wr,
  output logic                  period_end,
  output logic [PWM_BITS-1:0]   pwm_cnt
);

  logic [PRESC_BITS-1:0] presc_cnt_q, presc_cnt_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic                  tick;

  always_comb begin
    tick       = (presc_cnt_q == presc);
    period_end = tick & (&pwm_cnt_q);
    // A reload write restarts the prescaler phase on the same edge.
    presc_cnt_d = (presc_wr || tick) ? '0 : presc_cnt_q + PRESC_BITS'(1);
    pwm_cnt_d   = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

  assign pwm_cnt = pwm_cnt_q;

endmodule

// File: rtl/waves_nios_led_ctrl.sv
// Avalon-MM LED port with per-bit static/PWM mode and period-synchronised duty.
// Define LED_CTRL_FADE_EN to step the active duty by one toward the target per period.
module waves_nios_led_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned PRESC_BITS = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  import waves_nios_led_pkg::*;

  logic [WIDTH-1:0]      data_q, data_d;
  logic [WIDTH-1:0]      mode_q, mode_d;
  logic [PWM_BITS-1:0]   target_q, target_d;
  logic [PWM_BITS-1:0]   active_q, active_d;
  logic                  pending_q, pending_d;
  logic [PRESC_BITS-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]      out_q, out_d;

  logic                  wr, duty_wr, presc_wr;
  logic                  period_end;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [WIDTH-1:0]      wdata;
  logic                  unused_wdata;

  assign unused_wdata = ^writedata;
  assign wdata        = writedata[WIDTH-1:0];
  assign wr           = chipselect & ~write_n;
  assign duty_wr      = wr && (address == ADDR_DUTY);
  assign presc_wr     = wr && (address == ADDR_PRESC);

  waves_nios_led_pwm_timer #(
    .PWM_BITS   (PWM_BITS),
    .PRESC_BITS (PRESC_BITS)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .presc      (presc_q),
    .presc_wr   (presc_wr),
    .period_end (period_end),
    .pwm_cnt    (pwm_cnt)
  );

  always_comb begin
    data_d   = data_q;
    mode_d   = mode_q;
    target_d = target_q;
    presc_d  = presc_q;
    if (wr) begin
      case (address)
        ADDR_DATA:  data_d   = wdata;
        ADDR_MODE:  mode_d   = wdata;
        ADDR_DUTY:  target_d = writedata[PWM_BITS-1:0];
        ADDR_PRESC: presc_d  = writedata[PRESC_BITS-1:0];
        ADDR_SET:   data_d   = data_q | wdata;
        ADDR_CLEAR: data_d   = data_q & ~wdata;
        default:    ;
      endcase
    end
  end

  // Shadow update uses the target held before this edge, so a coinciding
  // DUTY write is deferred to the following period.
  always_comb begin
`ifdef LED_CTRL_FADE_EN
    active_d = active_q;
    if (period_end) begin
      if (active_q < target_q) begin
        active_d = active_q + PWM_BITS'(1);
      end else if (active_q > target_q) begin
        active_d = active_q - PWM_BITS'(1);
      end
    end
    pending_d = period_end ? (active_d != target_q) : pending_q;
`else
    active_d  = period_end ? target_q : active_q;
    pending_d = period_end ? 1'b0 : pending_q;
`endif
    if (duty_wr) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    out_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out_d[i] = data_q[i] & ((mode_q[i] == MODE_PWM) ? (pwm_cnt < active_q) : 1'b1);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:  readdata[WIDTH-1:0]      = data_q;
      ADDR_MODE:  readdata[WIDTH-1:0]      = mode_q;
      ADDR_DUTY:  readdata[PWM_BITS-1:0]   = target_q;
      ADDR_PRESC: readdata[PRESC_BITS-1:0] = presc_q;
      ADDR_STATUS: begin
        readdata[STATUS_PENDING_BIT]              = pending_q;
        readdata[STATUS_DUTY_LSB +: PWM_BITS]     = active_q;
      end
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q    <= '0;
      mode_q    <= '0;
      target_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      presc_q   <= '0;
      out_q     <= '0;
    end else begin
      data_q    <= data_d;
      mode_q    <= mode_d;
      target_q  <= target_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      presc_q   <= presc_d;
      out_q     <= out_d;
    end
  end

  assign out_port = out_q;

endmodule

// File: tb/tb_waves_nios_led_ctrl.sv
// Scoreboard bench: a cycle-count reference model predicts out_port and register reads.
module tb_waves_nios_led_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  always #5 clk = ~clk;

  waves_nios_led_ctrl #(
    .WIDTH      (8),
    .PWM_BITS   (8),
    .PRESC_BITS (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  a;
    logic [31:0] v;
  } rd_t;

  logic [7:0] exp_out_q[$];
  rd_t        rd_q[$];
  logic       rd_valid = 1'b0;

  // Reference state: registers plus elapsed cycles since the last phase restart
  // and the total number of prescaler ticks seen.
  logic [7:0]  m_data = '0, m_mode = '0, m_target = '0, m_active = '0;
  bit          m_pending = 0;
  int unsigned m_presc = 0, m_phase = 0, m_ticks = 0;

  function automatic bit m_tick();
    return (m_phase % (m_presc + 1)) == m_presc;
  endfunction

  function automatic bit m_pe_next();
    return m_tick() && ((m_ticks % 256) == 255);
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {24'h0, m_data};
      3'd1:    return {24'h0, m_mode};
      3'd2:    return {24'h0, m_target};
      3'd3:    return m_presc;
      3'd6:    return {8'h0, m_active, 15'h0, m_pending};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_step();
    logic [7:0] o;
    bit         tk, pe;
    int         pwm;
    if (!reset_n) begin
      m_data = '0; m_mode = '0; m_target = '0; m_active = '0; m_pending = 0;
      m_presc = 0; m_phase = 0; m_ticks = 0;
      exp_out_q.push_back(8'h00);
      return;
    end
    tk  = m_tick();
    pwm = m_ticks % 256;
    pe  = tk && (pwm == 255);
    for (int i = 0; i < 8; i++) begin
      o[i] = m_data[i] && (m_mode[i] ? (pwm < int'(m_active)) : 1'b1);
    end
    exp_out_q.push_back(o);
    if (pe) begin
`ifdef LED_CTRL_FADE_EN
      if (m_active < m_target) m_active = m_active + 8'd1;
      else if (m_active > m_target) m_active = m_active - 8'd1;
      m_pending = (m_active != m_target);
`else
      m_active  = m_target;
      m_pending = 0;
`endif
    end
    m_phase++;
    if (tk) m_ticks++;
    if (chipselect && !write_n) begin
      case (address)
        3'd0: m_data = writedata[7:0];
        3'd1: m_mode = writedata[7:0];
        3'd2: begin m_target = writedata[7:0]; m_pending = 1; end
        3'd3: begin m_presc = writedata[15:0]; m_phase = 0; end
        3'd4: m_data = m_data | writedata[7:0];
        3'd5: m_data = m_data & ~writedata[7:0];
        default: ;
      endcase
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: out_port every cycle, readdata whenever a read is presented.
  initial begin
    logic [7:0] e;
    rd_t        r;
    forever begin
      @(negedge clk);
      if (exp_out_q.size() > 0) begin
        e = exp_out_q.pop_front();
        checks++;
        if (out_port !== e) begin
          errors++;
          $display("FAIL out_port: got %h expected %h at %0t", out_port, e, $time);
        end
      end
      if (rd_valid) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL read_queue: read presented with no expectation at %0t", $time);
        end else begin
          r = rd_q.pop_front();
          if (readdata !== r.v) begin
            errors++;
            $display("FAIL read addr%0d: got %h expected %h at %0t", r.a, readdata, r.v, $time);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    idle(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic do_read(input logic [2:0] a);
    rd_t r;
    chipselect = 1'b1; write_n = 1'b1; address = a;
    r.a = a;
    r.v = m_read(a);
    rd_q.push_back(r);
    rd_valid = 1'b1;
    idle(1);
    rd_valid = 1'b0; chipselect = 1'b0;
  endtask

  // Leaves the bench just before the edge on which period_end fires.
  task automatic wait_pe();
    int g = 0;
    while (!m_pe_next() && g < 300000) begin
      idle(1);
      g++;
    end
    if (g >= 300000) begin
      checks++;
      errors++;
      $display("FAIL wait_pe: no period end within %0d cycles", g);
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
  endtask

  initial begin
    int r;
    repeat (3) @(posedge clk);
    #1;
    for (int a = 0; a < 8; a++) do_read(3'(a));
    reset_n = 1'b1;
    idle(2);

    // Static output and register readback.
    bus_write(3'd0, 32'hA5);
    bus_write(3'd1, 32'h00);
    idle(2);
    do_read(3'd0);

    // Atomic set/clear.
    bus_write(3'd0, 32'hFF);
    bus_write(3'd4, 32'h00);
    bus_write(3'd5, 32'h0F);
    do_read(3'd0);
    do_read(3'd4);
    do_read(3'd5);
    idle(2);

    // PWM with duty 64 and prescaler 0.
    bus_write(3'd3, 32'h0);
    bus_write(3'd2, 32'd64);
    bus_write(3'd1, 32'h01);
    bus_write(3'd0, 32'h01);
    do_read(3'd6);
    wait_pe();
    idle(1);
    do_read(3'd6);
    idle(520);

    // Mid-period DUTY write, then one coinciding with period_end.
    idle(20);
    bus_write(3'd2, 32'd128);
    do_read(3'd6);
    idle(100);
    do_read(3'd6);
    wait_pe();
    bus_write(3'd2, 32'd200);
    do_read(3'd6);
    do_read(3'd2);
    wait_pe();
    idle(1);
    do_read(3'd6);
    idle(300);

    // Prescaler 3, phase restart, reset mid-period.
    bus_write(3'd3, 32'd3);
    do_read(3'd3);
    idle(1100);
    idle(2);
    bus_write(3'd3, 32'd3);
    idle(600);
    pulse_reset();
    for (int a = 0; a < 8; a++) do_read(3'(a));

    // Duty stepping toward a target and redirect (plain load when fade is off).
    bus_write(3'd0, 32'h01);
    bus_write(3'd1, 32'h01);
    bus_write(3'd2, 32'd4);
    repeat (4) begin
      wait_pe();
      idle(1);
      do_read(3'd6);
    end
    bus_write(3'd2, 32'd2);
    repeat (2) begin
      wait_pe();
      idle(1);
      do_read(3'd6);
    end

    // Randomized traffic.
    for (int it = 0; it < 4000; it++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        logic [2:0]  a;
        logic [31:0] d;
        a = 3'($urandom_range(0, 7));
        d = $urandom();
        if (a == 3'd3) d = $urandom_range(0, 2);
        bus_write(a, d);
      end else if (r < 16) begin
        do_read(3'($urandom_range(0, 7)));
      end else if (r == 99 && $urandom_range(0, 19) == 0) begin
        pulse_reset();
      end else begin
        idle(1);
      end
    end

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
